// File: rtl/modbus_exception_check.sv
// Validates a received Modbus RTU request (CRC, function, address, value) and
// reports one exception code per frame. Optional macro: EXCEPTIONS_WR_VALUE_CHECK_EN.
module modbus_exception_check #(
   parameter logic [15:0] REG_NUM      = 16'd2,
   parameter logic [15:0] QTY_MAX      = 16'd125,
   parameter logic [15:0] WR_VALUE_MAX = 16'hFFFF,
   parameter logic [15:0] CRC_TIMEOUT  = 16'd1000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rx_message_done,
   input  logic [7:0]  func_code,
   input  logic [15:0] addr,
   input  logic [15:0] data,
   input  logic [15:0] crc_rx_code,
   input  logic        crc_done,
   input  logic [15:0] crc_rx_calc,
   output logic        exception_done,
   output logic [7:0]  exception
);

   typedef enum logic {IDLE, WAIT_CRC} state_t;

   state_t      state, state_next;
   logic [15:0] timer, timer_next;
   logic [7:0]  func_q;
   logic [15:0] addr_q, data_q, crc_code_q;
   logic        latch_en, eval_en;
   logic        wr_value_bad;
   logic [16:0] rd_end;
   logic [7:0]  result;

`ifdef EXCEPTIONS_WR_VALUE_CHECK_EN
   assign wr_value_bad = (data_q > WR_VALUE_MAX);
`else
   // Tied off: every 16-bit write value is legal in this build.
   assign wr_value_bad = 1'b0 & (data_q > WR_VALUE_MAX);
`endif

   // 17-bit end address so addr + quantity cannot wrap past REG_NUM.
   assign rd_end = {1'b0, addr_q} + {1'b0, data_q};

   always_comb begin
      result = 8'h00;
      if (crc_rx_calc != {crc_code_q[7:0], crc_code_q[15:8]}) begin
         result = 8'hFF;
      end else if (func_q == 8'h03) begin
         if (data_q == 16'd0 || data_q > QTY_MAX)
            result = 8'h03;
         else if (rd_end > {1'b0, REG_NUM})
            result = 8'h02;
      end else if (func_q == 8'h06) begin
         if (addr_q >= REG_NUM)
            result = 8'h02;
         else if (wr_value_bad)
            result = 8'h03;
      end else begin
         result = 8'h01;
      end
   end

   always_comb begin
      state_next = state;
      timer_next = timer;
      latch_en   = 1'b0;
      eval_en    = 1'b0;
      case (state)
         IDLE: begin
            if (rx_message_done) begin
               latch_en   = 1'b1;
               timer_next = 16'd0;
               state_next = WAIT_CRC;
            end
         end
         WAIT_CRC: begin
            // A fresh frame takes precedence over a coincident crc_done.
            if (rx_message_done) begin
               latch_en   = 1'b1;
               timer_next = 16'd0;
            end else if (crc_done) begin
               eval_en    = 1'b1;
               timer_next = 16'd0;
               state_next = IDLE;
            end else if (timer >= CRC_TIMEOUT - 16'd1) begin
               timer_next = 16'd0;
               state_next = IDLE;
            end else begin
               timer_next = timer + 16'd1;
            end
         end
         default: begin
            timer_next = 16'd0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= IDLE;
         timer          <= 16'd0;
         func_q         <= 8'h00;
         addr_q         <= 16'd0;
         data_q         <= 16'd0;
         crc_code_q     <= 16'd0;
         exception      <= 8'h00;
         exception_done <= 1'b0;
      end else begin
         state          <= state_next;
         timer          <= timer_next;
         exception_done <= eval_en;
         if (latch_en) begin
            func_q     <= func_code;
            addr_q     <= addr;
            data_q     <= data;
            crc_code_q <= crc_rx_code;
         end
         if (eval_en)
            exception <= result;
      end
   end

endmodule

// File: tb/tb_modbus_exception_check.sv
// Directed bench for modbus_exception_check (REG_NUM=2, QTY_MAX=125,
// WR_VALUE_MAX=4, CRC_TIMEOUT=20).
module tb_modbus_exception_check;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_message_done = 1'b0;
   logic [7:0]  func_code = 8'h00;
   logic [15:0] addr = 16'd0;
   logic [15:0] data = 16'd0;
   logic [15:0] crc_rx_code = 16'd0;
   logic        crc_done = 1'b0;
   logic [15:0] crc_rx_calc = 16'd0;
   logic        exception_done;
   logic [7:0]  exception;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   modbus_exception_check #(
      .REG_NUM(16'd2), .QTY_MAX(16'd125), .WR_VALUE_MAX(16'd4), .CRC_TIMEOUT(16'd20)
   ) dut (
      .clk_in(sys_clk), .rst_n_in(reset_n),
      .rx_message_done(rx_message_done), .func_code(func_code),
      .addr(addr), .data(data), .crc_rx_code(crc_rx_code),
      .crc_done(crc_done), .crc_rx_calc(crc_rx_calc),
      .exception_done(exception_done), .exception(exception)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_rx(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] code);
      @(posedge sys_clk); #1;
      rx_message_done = 1'b1; func_code = f; addr = a; data = d; crc_rx_code = code;
      @(posedge sys_clk); #1;
      rx_message_done = 1'b0; func_code = 8'hAA; addr = 16'hDEAD; data = 16'hBEEF;
      crc_rx_code = 16'h0000;
   endtask

   // crc_done sampled at edge N; outputs checked just after N and after N+1.
   task automatic send_crc(input string tag, input logic [15:0] calc,
                           input logic expect_done, input logic [7:0] exp);
      @(posedge sys_clk); #1;
      crc_done = 1'b1; crc_rx_calc = calc;
      @(posedge sys_clk); #1;
      crc_done = 1'b0; crc_rx_calc = 16'h5A5A;
      check({tag, "_done"}, {7'd0, exception_done}, {7'd0, expect_done});
      check({tag, "_code"}, exception, exp);
      @(posedge sys_clk); #1;
      check({tag, "_done_low"}, {7'd0, exception_done}, 8'h00);
      check({tag, "_hold"}, exception, exp);
   endtask

   task automatic frame(input string tag, input logic [7:0] f, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] code,
                        input logic [15:0] calc, input logic [7:0] exp);
      send_rx(f, a, d, code);
      repeat (2) @(posedge sys_clk);
      send_crc(tag, calc, 1'b1, exp);
   endtask

   initial begin
      repeat (2) @(posedge sys_clk); #1;
      check("reset_code", exception, 8'h00);
      check("reset_done", {7'd0, exception_done}, 8'h00);
      reset_n = 1'b1;

      frame("rd_ok",       8'h03, 16'h0001, 16'h0001, 16'hD5CA, 16'hCAD5, 8'h00);
      frame("wr_bad_addr", 8'h06, 16'h0002, 16'h0005, 16'hE809, 16'h09E8, 8'h02);
`ifdef EXCEPTIONS_WR_VALUE_CHECK_EN
      frame("wr_val_5",    8'h06, 16'h0001, 16'h0005, 16'h1234, 16'h3412, 8'h03);
`else
      frame("wr_val_5",    8'h06, 16'h0001, 16'h0005, 16'h1234, 16'h3412, 8'h00);
`endif
      frame("wr_val_4",    8'h06, 16'h0001, 16'h0004, 16'h1234, 16'h3412, 8'h00);
      frame("bad_func",    8'h05, 16'h0000, 16'h0001, 16'h1234, 16'h3412, 8'h01);
      frame("qty_zero",    8'h03, 16'h0000, 16'h0000, 16'h1234, 16'h3412, 8'h03);
      frame("rd_overrun",  8'h03, 16'h0001, 16'h0002, 16'h1234, 16'h3412, 8'h02);
      frame("rd_full",     8'h03, 16'h0000, 16'h0002, 16'h1234, 16'h3412, 8'h00);
      frame("qty_max",     8'h03, 16'h0000, 16'd125,  16'h1234, 16'h3412, 8'h02);
      frame("qty_over",    8'h03, 16'h0000, 16'd126,  16'h1234, 16'h3412, 8'h03);
      frame("rd_nowrap",   8'h03, 16'hFFFF, 16'h0001, 16'h1234, 16'h3412, 8'h02);
      frame("crc_bad",     8'h03, 16'h0001, 16'h0001, 16'hD5CB, 16'hCAD5, 8'hFF);
      frame("crc_over_fn", 8'h05, 16'h0000, 16'h0001, 16'h1234, 16'h3413, 8'hFF);

      // crc_done with no pending frame is ignored.
      send_crc("idle_crc", 16'h3412, 1'b0, 8'hFF);

      // rx_message_done wins over a coincident crc_done and re-latches fields.
      send_rx(8'h05, 16'h0000, 16'h0001, 16'h1234);
      @(posedge sys_clk); #1;
      rx_message_done = 1'b1; func_code = 8'h06; addr = 16'h0000; data = 16'h0001;
      crc_rx_code = 16'hABCD; crc_done = 1'b1; crc_rx_calc = 16'h3412;
      @(posedge sys_clk); #1;
      rx_message_done = 1'b0; crc_done = 1'b0;
      check("collide_no_done", {7'd0, exception_done}, 8'h00);
      check("collide_hold", exception, 8'hFF);
      send_crc("relatched", 16'hCDAB, 1'b1, 8'h00);

      // Timeout returns to IDLE silently; a late crc_done is then ignored.
      frame("pre_to", 8'h06, 16'h0002, 16'h0000, 16'h1234, 16'h3412, 8'h02);
      send_rx(8'h03, 16'h0000, 16'h0001, 16'h1234);
      repeat (25) @(posedge sys_clk);
      #1 check("timeout_no_done", {7'd0, exception_done}, 8'h00);
      send_crc("after_timeout", 16'h3412, 1'b0, 8'h02);

      // Reset in WAIT_CRC clears outputs and abandons the frame.
      send_rx(8'h03, 16'h0000, 16'h0001, 16'h1234);
      @(posedge sys_clk); #1;
      reset_n = 1'b0;
      #2;
      check("rst_mid_code", exception, 8'h00);
      check("rst_mid_done", {7'd0, exception_done}, 8'h00);
      @(posedge sys_clk); #1;
      reset_n = 1'b1;
      send_crc("after_reset", 16'h3412, 1'b0, 8'h00);

      // Block still works after reset.
      frame("post_reset", 8'h03, 16'h0001, 16'h0001, 16'hD5CA, 16'hCAD5, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
